// File: rtl/fbp_batch_scheduler.sv
// fbp_batch_scheduler: frame-level sequencer for the back-projection pipeline
// group. Splits a frame of total_angles projection angles into batches of
// PIPELINES_NUM angles; each batch is loaded, configured, started and awaited,
// under a completion watchdog and an abort path.
module fbp_batch_scheduler #(
  parameter int PIPELINES_NUM  = 60,
  parameter int ANGLE_W        = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               frame_start,
  input  logic               abort,
  input  logic [ANGLE_W:0]   total_angles,
  output logic               busy,
  output logic               frame_done,
  output logic               err_timeout,
  output logic [ANGLE_W-1:0] batch_idx,
  output logic               load_req,
  output logic [ANGLE_W-1:0] load_angle_base,
  output logic [ANGLE_W-1:0] load_angle_cnt,
  input  logic               load_done,
  output logic [ANGLE_W-1:0] angle_num,
  output logic               angle_num_valid,
  output logic               start_calc,
  input  logic               finsh_calc
);

  // Base is one bit wider than angle_num so it can reach the frame total
  // without wrapping; the sum is one bit wider again so base+step never wraps.
  localparam int BW = ANGLE_W + 1;
  localparam int SW = ANGLE_W + 2;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0]      LP_STEP      = SW'(PIPELINES_NUM);
  localparam logic [ANGLE_W-1:0] LP_FULL_CNT  = ANGLE_W'(PIPELINES_NUM);
  localparam logic [CW-1:0]      LP_WDOG_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONFIG,
    S_START,
    S_CALC,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_accept;
  logic               w_timeout;
  logic               w_advance;

  logic [BW-1:0]      r_total;
  logic [BW-1:0]      r_base;
  logic [SW-1:0]      w_base_sum;
  logic [CW-1:0]      r_wdog;

  logic               r_busy;
  logic               r_frame_done;
  logic               r_err_timeout;
  logic [ANGLE_W-1:0] r_batch_idx;
  logic               r_load_req;
  logic [ANGLE_W-1:0] r_load_angle_cnt;
  logic [ANGLE_W-1:0] r_angle_num;
  logic               r_angle_num_valid;
  logic               r_start_calc;

  // Lanes valid in a batch starting at base: min(PIPELINES_NUM, total - base),
  // clamped at zero once the base has passed the total.
  function automatic logic [ANGLE_W-1:0] batch_cnt(input logic [BW-1:0] total,
                                                   input logic [SW-1:0] base);
    logic [SW-1:0] rem;
    rem = ({1'b0, total} > base) ? ({1'b0, total} - base) : '0;
    return (rem > LP_STEP) ? LP_FULL_CNT : rem[ANGLE_W-1:0];
  endfunction

  assign w_base_sum = {1'b0, r_base} + LP_STEP;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic plus the one-cycle events that steer the datapath.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_accept     = 1'b1;
          w_next_state = (total_angles == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:   if (load_done) w_next_state = S_CONFIG;
      S_CONFIG: w_next_state = S_START;
      S_START:  w_next_state = S_CALC;
      S_CALC: begin
        // Completion beats the watchdog when both land in the same cycle.
        if (finsh_calc) begin
          w_next_state = S_NEXT;
        end else if (r_wdog == LP_WDOG_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_NEXT: begin
        w_advance    = 1'b1;
        w_next_state = (w_base_sum >= {1'b0, r_total}) ? S_DONE : S_LOAD;
      end
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
    // Abort overrides every transition, including a start request in IDLE.
    if (abort) begin
      w_next_state = S_IDLE;
      w_accept     = 1'b0;
      w_timeout    = 1'b0;
      w_advance    = 1'b0;
    end
  end

  // Completion watchdog: cleared in START, counts cycles spent in CALC.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wdog <= '0;
    end else if (r_state == S_START) begin
      r_wdog <= '0;
    end else if (r_state == S_CALC && r_wdog != LP_WDOG_LAST) begin
      r_wdog <= r_wdog + CW'(1);
    end
  end

  // Registered outputs and batch bookkeeping; strobes are decoded from the
  // next state so each one is high exactly for the cycle spent in its state.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_busy            <= 1'b0;
      r_frame_done      <= 1'b0;
      r_err_timeout     <= 1'b0;
      r_batch_idx       <= '0;
      r_load_req        <= 1'b0;
      r_load_angle_cnt  <= '0;
      r_angle_num       <= '0;
      r_angle_num_valid <= 1'b0;
      r_start_calc      <= 1'b0;
      r_total           <= '0;
      r_base            <= '0;
    end else begin
      r_busy            <= (w_next_state != S_IDLE);
      r_load_req        <= (w_next_state == S_LOAD);
      r_angle_num_valid <= (w_next_state == S_CONFIG);
      r_start_calc      <= (w_next_state == S_START);
      r_frame_done      <= (w_next_state == S_DONE);

      if (w_next_state == S_CONFIG) r_angle_num <= r_base[ANGLE_W-1:0];

      if (w_accept) begin
        r_total          <= total_angles;
        r_base           <= '0;
        r_batch_idx      <= '0;
        r_load_angle_cnt <= batch_cnt(total_angles, '0);
        r_err_timeout    <= 1'b0;
      end else if (w_advance) begin
        r_base           <= w_base_sum[BW-1:0];
        r_batch_idx      <= r_batch_idx + ANGLE_W'(1);
        r_load_angle_cnt <= batch_cnt(r_total, w_base_sum);
      end

      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign busy            = r_busy;
  assign frame_done      = r_frame_done;
  assign err_timeout     = r_err_timeout;
  assign batch_idx       = r_batch_idx;
  assign load_req        = r_load_req;
  assign load_angle_base = r_base[ANGLE_W-1:0];
  assign load_angle_cnt  = r_load_angle_cnt;
  assign angle_num       = r_angle_num;
  assign angle_num_valid = r_angle_num_valid;
  assign start_calc      = r_start_calc;

endmodule
